// File: rtl/score_bcd_display.sv
// ---------------------------------------------------------------------------
// score_bcd_display
//   N-digit seven-segment driver for the game score and debug values.
//   A binary value is converted to BCD with a sequential double-dabble
//   (one shift per clock). When the conversion finishes, the BCD digits and
//   their segment patterns are registered together, so the board's
//   seg1..segN pins never see intermediate values. One further request can
//   be queued while a conversion is running; the newest request wins.
//
// Parameters
//   BIN_WIDTH      width of the binary input value (>= 4)
//   NUM_DIGITS     number of displayed decimal digits (1..8)
//   BLANK_LEADING  1: blank zero digits above the most significant non-zero digit
//   SEG_ACTIVE_LOW 1: a lit segment is driven 0; 0: a lit segment is driven 1
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   load      in   request to convert value (sampled every cycle)
//   value     in   binary value to display
//   busy      out  conversion in progress
//   done      out  one-cycle pulse in the cycle the outputs update
//   overflow  out  last conversion did not fit in NUM_DIGITS (held until next done)
//   bcd       out  digit i at [4i+3:4i], digit 0 least significant
//   seg       out  digit i at [7i+6:7i] = {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module score_bcd_display #(
  parameter int BIN_WIDTH      = 20,
  parameter int NUM_DIGITS     = 6,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BIN_WIDTH-1:0]    value,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int ACC_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]           state;
  logic [BIN_WIDTH-1:0] sr;
  logic [BIN_WIDTH-1:0] sr_next;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_adj;
  logic [ACC_W-1:0]     acc_next;
  logic [ACC_W-1:0]     commit_bcd;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_sticky;
  logic                 ovf_next;
  logic [BIN_WIDTH-1:0] hold;
  logic                 pending;
  logic [SEG_W-1:0]     reset_seg;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  // Codes above 9 cannot occur in a committed value and show blank.
  function automatic logic [6:0] digit_pattern(input logic [3:0] d);
    case (d)
      4'd0:    digit_pattern = 7'b0111111;
      4'd1:    digit_pattern = 7'b0000110;
      4'd2:    digit_pattern = 7'b1011011;
      4'd3:    digit_pattern = 7'b1001111;
      4'd4:    digit_pattern = 7'b1100110;
      4'd5:    digit_pattern = 7'b1101101;
      4'd6:    digit_pattern = 7'b1111101;
      4'd7:    digit_pattern = 7'b0000111;
      4'd8:    digit_pattern = 7'b1111111;
      4'd9:    digit_pattern = 7'b1101111;
      default: digit_pattern = 7'b0000000;
    endcase
  endfunction

  // Full segment vector for a BCD word. Walking from the top digit down,
  // a digit is blanked while it and everything above it is zero; digit 0 is
  // always shown. A saturated (all 9s) word has no zeros, so nothing blanks.
  function automatic logic [SEG_W-1:0] segs_for(input logic [ACC_W-1:0] d);
    logic             upper_zero;
    logic             this_zero;
    logic [6:0]       pat;
    logic [SEG_W-1:0] result;
    upper_zero = 1'b1;
    result     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      this_zero  = upper_zero && (d[4*i +: 4] == 4'd0);
      pat        = digit_pattern(d[4*i +: 4]);
      if ((BLANK_LEADING != 0) && (i != 0) && this_zero) begin
        pat = 7'b0000000;
      end
      if (SEG_ACTIVE_LOW != 0) begin
        pat = ~pat;
      end
      result[7*i +: 7] = pat;
      upper_zero       = this_zero;
    end
    return result;
  endfunction

  // One double-dabble step: bias every digit >= 5 by 3, then shift the
  // concatenated {accumulator, shift register} left by one. A 1 leaving the
  // top digit means the value cannot fit, and that is remembered until the
  // next conversion starts; this is the only saturation detector.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    acc_next   = {acc_adj[ACC_W-2:0], sr[BIN_WIDTH-1]};
    sr_next    = {sr[BIN_WIDTH-2:0], 1'b0};
    ovf_next   = ovf_sticky | acc_adj[ACC_W-1];
    commit_bcd = ovf_next ? {NUM_DIGITS{4'h9}} : acc_next;
  end

  // Pattern shown after reset: a single "0" on digit 0.
  assign reset_seg = segs_for({ACC_W{1'b0}});

  assign busy = (state != IDLE);

  // Conversion sequencer. The displayed outputs are loaded on the same edge
  // as the final shift, so done, bcd, seg and overflow all change together
  // and are stable for the whole COMMIT cycle. While busy, a load only
  // refreshes the hold register; in COMMIT a queued (or same-cycle) request
  // restarts the shifter immediately so busy never drops between the two.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      hold       <= '0;
      pending    <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      bcd        <= '0;
      seg        <= reset_seg;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            sr         <= value;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sr         <= sr_next;
          acc        <= acc_next;
          ovf_sticky <= ovf_next;
          cnt        <= cnt + 1'b1;
          if (load) begin
            hold    <= value;
            pending <= 1'b1;
          end
          if (cnt == LAST_SHIFT) begin
            state    <= COMMIT;
            done     <= 1'b1;
            overflow <= ovf_next;
            bcd      <= commit_bcd;
            seg      <= segs_for(commit_bcd);
          end
        end
        COMMIT: begin
          if (pending || load) begin
            sr         <= load ? value : hold;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            pending    <= 1'b0;
            state      <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// ---------------------------------------------------------------------------
// tb_score_bcd_display
//   Directed bench for score_bcd_display. Instance dut is 20-bit / 6 digits
//   with leading-zero blanking; instance dut4 is 4 digits without blanking.
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_score_bcd_display;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [19:0] value = '0;
  logic        busy, done, overflow;
  logic [23:0] bcd;
  logic [41:0] seg;

  logic        load2  = 1'b0;
  logic [19:0] value2 = '0;
  logic        busy2, done2, overflow2;
  logic [15:0] bcd2;
  logic [27:0] seg2;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [41:0] RESET_SEG = {SEG_BLANK, SEG_BLANK, SEG_BLANK,
                                       SEG_BLANK, SEG_BLANK, SEG_0};

  score_bcd_display #(
    .BIN_WIDTH(20), .NUM_DIGITS(6), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .load(load), .value(value),
    .busy(busy), .done(done), .overflow(overflow), .bcd(bcd), .seg(seg)
  );

  score_bcd_display #(
    .BIN_WIDTH(20), .NUM_DIGITS(4), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1)
  ) dut4 (
    .clock(clock), .reset(reset), .load(load2), .value(value2),
    .busy(busy2), .done(done2), .overflow(overflow2), .bcd(bcd2), .seg(seg2)
  );

  // 10 ns clock; the bench drives and samples on the falling edge.
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Hold load for exactly one cycle; returns in the first SHIFT cycle.
  task automatic applyStimulus(input logic [19:0] v);
    @(negedge clock);
    load  = 1'b1;
    value = v;
    @(negedge clock);
    load  = 1'b0;
  endtask

  // Counts cycles from the load cycle (cycle 1 = first cycle after load)
  // until done is seen, bounded at 100.
  task automatic waitDone(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int n_done;
    int busy_dropped;
    logic [23:0] first_bcd;
    logic [23:0] second_bcd;

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
    checkOutput("rst_bcd", bcd, 24'h0);
    checkOutput("rst_seg", seg, RESET_SEG);
    checkOutput("rst_seg_noblank", seg2, {4{SEG_0}});

    // 1. 12345, exact latency and blanking of digit 5
    applyStimulus(20'd12345);
    checkOutput("t1_busy_next", busy, 1'b1);
    waitDone(lat);
    checkOutput("t1_latency", lat, 21);
    checkOutput("t1_bcd", bcd, 24'h012345);
    checkOutput("t1_seg", seg, {SEG_BLANK, 7'b1111001, 7'b0100100,
                                7'b0110000, 7'b0011001, 7'b0010010});
    checkOutput("t1_overflow", overflow, 1'b0);
    @(negedge clock);
    checkOutput("t1_done_pulse", done, 1'b0);
    checkOutput("t1_busy_after", busy, 1'b0);

    // 2. zero
    applyStimulus(20'd0);
    waitDone(lat);
    checkOutput("t2_latency", lat, 21);
    checkOutput("t2_bcd", bcd, 24'h0);
    checkOutput("t2_seg", seg, RESET_SEG);
    checkOutput("t2_overflow", overflow, 1'b0);
    @(negedge clock);

    // 3. saturation, then recovery
    applyStimulus(20'd1000000);
    waitDone(lat);
    checkOutput("t3_latency", lat, 21);
    checkOutput("t3_bcd_sat", bcd, 24'h999999);
    checkOutput("t3_overflow", overflow, 1'b1);
    checkOutput("t3_seg_sat", seg, {6{7'b0010000}});
    @(negedge clock);
    checkOutput("t3_overflow_held", overflow, 1'b1);
    applyStimulus(20'd42);
    waitDone(lat);
    checkOutput("t3_bcd_42", bcd, 24'h000042);
    checkOutput("t3_overflow_clr", overflow, 1'b0);
    checkOutput("t3_seg_42", seg, {SEG_BLANK, SEG_BLANK, SEG_BLANK,
                                   SEG_BLANK, 7'b0011001, 7'b0100100});
    @(negedge clock);

    // 4. queued request, last wins
    applyStimulus(20'd5);
    @(negedge clock);
    load  = 1'b1;
    value = 20'd7;
    @(negedge clock);
    value = 20'd9;
    @(negedge clock);
    load  = 1'b0;
    n_done       = 0;
    busy_dropped = 0;
    first_bcd    = '1;
    second_bcd   = '1;
    for (int i = 0; i < 70; i++) begin
      if (done === 1'b1) begin
        if (n_done == 0) first_bcd = bcd;
        if (n_done == 1) second_bcd = bcd;
        n_done++;
      end
      if (busy !== 1'b1 && n_done < 2) busy_dropped = 1;
      @(negedge clock);
    end
    checkOutput("t4_done_count", n_done, 2);
    checkOutput("t4_first_bcd", first_bcd, 24'h000005);
    checkOutput("t4_second_bcd", second_bcd, 24'h000009);
    checkOutput("t4_busy_held", busy_dropped, 0);
    checkOutput("t4_idle_after", busy, 1'b0);

    // 5. reset in the 10th SHIFT cycle aborts the conversion
    applyStimulus(20'd999999);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_bcd", bcd, 24'h0);
    checkOutput("t5_seg", seg, RESET_SEG);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) n_done++;
      @(negedge clock);
    end
    checkOutput("t5_no_done", n_done, 0);
    checkOutput("t5_bcd_later", bcd, 24'h0);

    // 6. no blanking, 4 digits
    @(negedge clock);
    load2  = 1'b1;
    value2 = 20'd7;
    @(negedge clock);
    load2  = 1'b0;
    lat    = 1;
    while (done2 !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("t6_latency", lat, 21);
    checkOutput("t6_bcd", bcd2, 16'h0007);
    checkOutput("t6_seg", seg2, {SEG_0, SEG_0, SEG_0, 7'b1111000});
    checkOutput("t6_overflow", overflow2, 1'b0);

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
